fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, sets the prefetch FIFO entry count (power of two, at least 2).
REQ-002 Parameter PC_STEP, default 4, sets the per-instruction address increment.
REQ-003 Parameter RESET_PC, default 16'h0000, sets the first fetch address.
REQ-004 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port mem_req, output, 1 bit: instruction-memory read request.
REQ-007 Port mem_addr, output, 16 bits: fetch address, valid while mem_req is high.
REQ-008 Port mem_ack, input, 1 bit: memory response strobe for the outstanding request.
REQ-009 Port mem_rdata, input, 16 bits: instruction word, valid in the mem_ack cycle.
REQ-010 Port stall, input, 1 bit: decode stage holds its IF/ID contents; no pop.
REQ-011 Port redirect, input, 1 bit: taken branch; flush and refetch.
REQ-012 Port redirect_pc, input, 16 bits: branch target, sampled when redirect is high.
REQ-013 Port hlt, input, 1 bit: halt; stop issuing new fetches.
REQ-014 Port out_valid, output, 1 bit: the FIFO head is valid.
REQ-015 Port out_instr, output, 16 bits: instruction word at the FIFO head.
REQ-016 Port out_pc_incr, output, 16 bits: the FIFO head's fetch address + PC_STEP.
REQ-017 Port pc, output, 16 bits: next address to be fetched.

Function
REQ-018 States: RUN (may issue), WAIT (one request outstanding), HALTED.
REQ-019 RUN -> WAIT when an issue occurs; WAIT -> RUN on mem_ack; RUN -> HALTED when hlt=1 and nothing is outstanding; WAIT -> HALTED on mem_ack when hlt=1; HALTED is left only by reset.
REQ-020 An issue occurs in RUN when (count + 0) < DEPTH: mem_req=1, mem_addr=pc, and pc advances by PC_STEP modulo 2^16 on the next edge.
REQ-021 In WAIT, mem_req and mem_addr are held stable until mem_ack; at most one request is outstanding.
REQ-022 On mem_ack, {mem_rdata, mem_addr+PC_STEP} is pushed, unless the request is squashed; out_valid is high no earlier than the next cycle.
REQ-023 Issue is gated by count + outstanding < DEPTH, so a push never overflows the FIFO.
REQ-024 out_valid = (count != 0); a pop occurs when out_valid=1 and stall=0; a push and a pop in the same cycle leave count unchanged.
REQ-025 While out_valid=0, out_instr and out_pc_incr hold their last value; consumers ignore them.
REQ-026 redirect=1 empties the FIFO (count=0) on that edge and overrides a same-cycle push and pop.
REQ-027 redirect=1 in RUN: pc <- redirect_pc, and no issue occurs in that cycle.
REQ-028 redirect=1 in WAIT: the outstanding request is marked squashed and redirect_pc is stored; on mem_ack the data is dropped and pc <- the stored target.
REQ-029 A second redirect before the ack overwrites the stored target, and the latest target wins.
REQ-030 A redirect and a mem_ack in the same cycle: the ack data is dropped and pc <- redirect_pc.
REQ-031 hlt does not flush the FIFO; remaining entries still drain to decode.
REQ-032 In HALTED, mem_req stays 0; redirect still empties the FIFO but causes no fetch.
REQ-033 The address wraps 16'hFFFC + 4 -> 16'h0000 silently.

Reset
REQ-034 Reset state: pc=RESET_PC, state=RUN, count=0, squash=0, mem_req=0, out_valid=0, out_instr=0, out_pc_incr=0.
REQ-035 Reset asserted mid-request abandons the request; a mem_ack arriving after reset release with no request outstanding is ignored.

Structure
REQ-036 The state encoding (RUN/WAIT/HALTED) and the defaults for PC_STEP and RESET_PC live in the shared CPU package.
REQ-037 The FIFO is a sub-module named fetch_fifo (DEPTH x 32 bits, wrapping pointers, flush input).

Verification
REQ-038 Reset, then mem_ack returned 1 cycle after each request -> fetches at addresses 0000, 0004, 0008; out_pc_incr sequence 0004, 0008, 000C.
REQ-039 stall held high for 8 cycles -> exactly 4 entries buffered, mem_req low while full; releasing stall drains in order with no loss or duplication.
REQ-040 redirect to 0x0040 while the request for 0x000C is outstanding, ack delayed 3 cycles -> 0x000C data never reaches out_valid; the next request is for 0x0040.
REQ-041 redirect in the same cycle as mem_ack and a pop -> FIFO empty; next mem_addr equals redirect_pc.
REQ-042 hlt asserted with 2 entries queued -> both entries pop, then mem_req stays 0 indefinitely.
REQ-043 Reset asserted during WAIT, then a late mem_ack -> no push, pc=0000, and mem_req restarts cleanly.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch path: FSM encoding,
// fetch defaults and the prefetch entry layout.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StWait   = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

  localparam logic [15:0] DefaultPcStep  = 16'd4;
  localparam logic [15:0] DefaultResetPc = 16'h0000;
  localparam int unsigned EntryWidth     = 32;

  // Entry layout: instruction word in the upper half, pc+step in the lower.
  function automatic logic [EntryWidth-1:0] pack_entry(input logic [15:0] instr,
                                                       input logic [15:0] pc_incr);
    return {instr, pc_incr};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with wrapping pointers and a flush that overrides push/pop.
// The head is registered so it holds its last value while the FIFO is empty.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [WIDTH-1:0] rdata_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d, count_left;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign rdata_o = head_q;

  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_left = count_q - CntW'(do_pop);
    rd_ptr_d   = rd_ptr_q + PtrW'(do_pop);
    wr_ptr_d   = wr_ptr_q + PtrW'(do_push);
    count_d    = count_left + CntW'(do_push);
    head_d     = head_q;
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else if (count_d != '0) begin
      // An entry pushed into an (effectively) empty FIFO becomes the head directly.
      head_d = (count_left == '0) ? wdata_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, results
// buffered in a prefetch FIFO for decode; handles redirects and halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] PC_STEP  = DefaultPcStep,
  parameter logic [15:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        hlt,
  output logic        out_valid,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc_incr,
  output logic [15:0] pc
);
  fetch_state_e          state_q;
  logic [15:0]           pc_q, addr_q, target_q;
  logic                  req_q, squash_q;
  logic                  fifo_full, push, pop;
  logic [EntryWidth-1:0] push_data, head;

  // Acks outside WAIT have no request behind them and are ignored.
  assign push      = (state_q == StWait) && mem_ack && !squash_q && !redirect;
  assign pop       = out_valid && !stall;
  assign push_data = pack_entry(mem_rdata, addr_q + PC_STEP);

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EntryWidth)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(redirect),
    .push_i (push),
    .wdata_i(push_data),
    .pop_i  (pop),
    .valid_o(out_valid),
    .full_o (fifo_full),
    .rdata_o(head)
  );

  assign out_instr   = head[31:16];
  assign out_pc_incr = head[15:0];
  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign pc          = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      target_q <= '0;
      req_q    <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (redirect) pc_q <= redirect_pc;
          if (hlt) begin
            state_q <= StHalted;
          end else if (!redirect && !fifo_full) begin
            state_q <= StWait;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
            pc_q    <= pc_q + PC_STEP;
          end
        end
        StWait: begin
          if (mem_ack) begin
            state_q  <= hlt ? StHalted : StRun;
            req_q    <= 1'b0;
            squash_q <= 1'b0;
            if (redirect)      pc_q <= redirect_pc;
            else if (squash_q) pc_q <= target_q;
          end else if (redirect) begin
            // Latest redirect wins; applied when the in-flight ack returns.
            squash_q <= 1'b1;
            target_q <= redirect_pc;
          end
        end
        StHalted: begin
          if (redirect) pc_q <= redirect_pc;
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a transaction-level model of
// fetch order and FIFO contents, checked by an independent monitor.
module tb_fetch_unit;
  localparam int unsigned DEPTH   = 4;
  localparam logic [15:0] PC_STEP = 16'd4;
  localparam logic [15:0] RST_PC  = 16'h0000;

  logic        clk, rst_n;
  logic        mem_req, mem_ack, stall, redirect, hlt, out_valid;
  logic [15:0] mem_addr, mem_rdata, redirect_pc, out_instr, out_pc_incr, pc;

  fetch_unit #(.DEPTH(DEPTH), .PC_STEP(PC_STEP), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .hlt(hlt), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc_incr(out_pc_incr), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] exp_q[$];
  logic [15:0] req_log[$];
  logic [15:0] pop_log[$];
  logic [15:0] model_pc, cur_addr, roa_tgt;
  logic [31:0] push_val;
  bit          push_pend, flush_pend, outstanding, squash, mon_en, rand_lat, roa, roa_hit;
  int          wait_cnt, ack_lat;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of memory + decode behaviour; inputs change on the falling edge.
  task automatic step(input bit s, input bit r, input logic [15:0] tgt, input bit h);
    bit ack;
    @(negedge clk);
    if (flush_pend) begin exp_q.delete(); flush_pend = 0; end
    if (push_pend) begin exp_q.push_back(push_val); push_pend = 0; end
    if (outstanding) begin
      chk("req_held", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, cur_addr});
    end else if (mem_req === 1'b1) begin
      chk("fetch_addr", mem_addr, model_pc);
      req_log.push_back(mem_addr);
      outstanding = 1;
      cur_addr    = model_pc;
      wait_cnt    = 0;
      model_pc    = model_pc + PC_STEP;
      if (rand_lat) ack_lat = $urandom_range(0, 3);
    end else begin
      chk("pc", pc, model_pc);
    end
    ack = 0;
    if (outstanding) begin
      if (wait_cnt >= ack_lat) ack = 1;
      else wait_cnt++;
    end
    if (roa && ack && out_valid) begin
      r = 1; tgt = roa_tgt; s = 0; roa_hit = 1;
    end
    stall = s; redirect = r; redirect_pc = tgt; hlt = h;
    mem_ack   = ack;
    mem_rdata = ack ? mem_word(cur_addr) : 16'($urandom);
    if (ack) begin
      outstanding = 0;
      if (!squash && !r) begin
        push_pend = 1;
        push_val  = {mem_word(cur_addr), cur_addr + PC_STEP};
      end
      squash = 0;
    end
    if (r) begin
      model_pc   = tgt;
      flush_pend = 1;
      if (outstanding) squash = 1;
    end
  endtask

  task automatic reset_dut(input bit late_ack);
    @(negedge clk);
    mon_en = 0;
    rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0; hlt = 0; mem_ack = 0; mem_rdata = 0;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_instr", {16'd0, out_instr}, 0);
    chk("rst_out_pc_incr", {16'd0, out_pc_incr}, 0);
    chk("rst_pc", {16'd0, pc}, {16'd0, RST_PC});
    exp_q.delete(); req_log.delete(); pop_log.delete();
    push_pend = 0; flush_pend = 0; outstanding = 0; squash = 0; model_pc = RST_PC;
    repeat (2) @(negedge clk);
    rst_n = 1;
    mem_ack   = late_ack;
    mem_rdata = 16'hDEAD;
    mon_en = 1;
  endtask

  // Monitor: compares the FIFO head with the scoreboard on every pop.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        if (out_valid && !stall && !redirect && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_instr", {16'd0, out_instr}, {16'd0, e[31:16]});
          chk("out_pc_incr", {16'd0, out_pc_incr}, {16'd0, e[15:0]});
          pop_log.push_back(out_pc_incr);
        end
      end
    end
  end

  initial begin
    int n_req;
    rst_n = 1; stall = 0; redirect = 0; redirect_pc = 0; hlt = 0; mem_ack = 0; mem_rdata = 0;
    mon_en = 0; rand_lat = 0; roa = 0; roa_hit = 0; ack_lat = 1; roa_tgt = 0;

    // Sequential fetch with a short ack latency
    reset_dut(0);
    ack_lat = 1;
    repeat (16) step(0, 0, 0, 0);
    chk("seq_req_count", {31'd0, req_log.size() >= 3}, 1);
    chk("seq_pop_count", {31'd0, pop_log.size() >= 3}, 1);
    if (req_log.size() >= 3 && pop_log.size() >= 3) begin
      chk("seq_addr0", {16'd0, req_log[0]}, 32'h0000);
      chk("seq_addr1", {16'd0, req_log[1]}, 32'h0004);
      chk("seq_addr2", {16'd0, req_log[2]}, 32'h0008);
      chk("seq_incr0", {16'd0, pop_log[0]}, 32'h0004);
      chk("seq_incr1", {16'd0, pop_log[1]}, 32'h0008);
      chk("seq_incr2", {16'd0, pop_log[2]}, 32'h000C);
    end

    // Stall until full, then drain
    ack_lat = 0;
    repeat (12) step(1, 0, 0, 0);
    repeat (4) begin
      step(1, 0, 0, 0);
      chk("full_no_req", {31'd0, mem_req}, 0);
      chk("full_entries", exp_q.size(), DEPTH);
    end
    repeat (20) step(0, 0, 0, 0);

    // Redirect while the request for 0x000C is outstanding, ack after 3 cycles
    reset_dut(0);
    ack_lat = 3;
    for (int i = 0; i < 40 && !(outstanding && cur_addr == 16'h000C); i++) step(0, 0, 0, 0);
    chk("reach_000c", {31'd0, outstanding && cur_addr == 16'h000C}, 1);
    req_log.delete();
    step(0, 1, 16'h0040, 0);
    for (int i = 0; i < 20 && req_log.size() == 0; i++) step(0, 0, 0, 0);
    chk("redir_wait_seen", {31'd0, req_log.size() != 0}, 1);
    if (req_log.size() != 0) chk("redir_wait_addr", {16'd0, req_log[0]}, 32'h0040);
    repeat (10) step(0, 0, 0, 0);

    // Redirect coinciding with an ack and a pop
    reset_dut(0);
    ack_lat = 1; roa = 1; roa_tgt = 16'h0100; roa_hit = 0;
    for (int i = 0; i < 40 && !roa_hit; i++) step(1, 0, 0, 0);
    roa = 0;
    chk("roa_hit", {31'd0, roa_hit}, 1);
    req_log.delete();
    step(0, 0, 0, 0);
    chk("roa_flush_empty", {31'd0, out_valid}, 0);
    for (int i = 0; i < 20 && req_log.size() == 0; i++) step(0, 0, 0, 0);
    chk("roa_seen", {31'd0, req_log.size() != 0}, 1);
    if (req_log.size() != 0) chk("roa_addr", {16'd0, req_log[0]}, 32'h0100);

    // Halt with entries queued
    reset_dut(0);
    ack_lat = 0;
    for (int i = 0; i < 30 && exp_q.size() < 2; i++) step(1, 0, 0, 0);
    chk("halt_prefill", {31'd0, exp_q.size() >= 2}, 1);
    repeat (4) step(0, 0, 0, 1);
    n_req = req_log.size();
    repeat (20) begin
      step(0, 0, 0, 1);
      chk("halt_no_req", {31'd0, mem_req}, 0);
    end
    chk("halt_drained", {31'd0, out_valid}, 0);
    step(0, 1, 16'h0200, 1);
    repeat (10) begin
      step(0, 0, 0, 1);
      chk("halt_redir_no_req", {31'd0, mem_req}, 0);
    end
    chk("halt_no_fetch", req_log.size(), n_req);

    // Reset in WAIT followed by a late ack
    reset_dut(0);
    ack_lat = 5;
    for (int i = 0; i < 10 && !outstanding; i++) step(0, 0, 0, 0);
    chk("wait_reached", {31'd0, outstanding}, 1);
    repeat (2) step(0, 0, 0, 0);
    reset_dut(1);
    step(0, 0, 0, 0);
    chk("late_ack_nopush", {31'd0, out_valid}, 0);
    ack_lat = 1;
    for (int i = 0; i < 10 && req_log.size() == 0; i++) step(0, 0, 0, 0);
    chk("restart_seen", {31'd0, req_log.size() != 0}, 1);
    if (req_log.size() != 0) chk("restart_addr", {16'd0, req_log[0]}, {16'd0, RST_PC});
    repeat (12) step(0, 0, 0, 0);

    // Random traffic, including targets near the top of the address space
    reset_dut(0);
    rand_lat = 1;
    repeat (500) begin
      logic [15:0] t;
      t = ($urandom_range(0, 3) == 0) ? 16'hFFF4 : (16'($urandom) & 16'hFFFC);
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, t, 0);
    end
    repeat (20) step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
